// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
//   Bundle of every signal between the register-file write arbiter and its
//   neighbours: pipeline writeback (A), multi-cycle unit result (B, valid/ready),
//   register-file write port, hazard-unit lookups, stall request, occupancy.
//   slave  : arbiter side (drives b_ready, rf_*, stall_req, pend_hit*, fifo_count)
//   master : surrounding pipeline side (drives a_*, b_valid/addr/data, rd_addr*)
interface rf_write_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          a_we;
  logic [4:0]    a_addr;
  logic [31:0]   a_data;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_addr;
  logic [31:0]   b_data;
  logic          rf_we;
  logic [4:0]    rf_addr;
  logic [31:0]   rf_data;
  logic          stall_req;
  logic [4:0]    rd_addr1;
  logic [4:0]    rd_addr2;
  logic          pend_hit1;
  logic          pend_hit2;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  a_we, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output b_ready,
    output rf_we, rf_addr, rf_data,
    output stall_req,
    input  rd_addr1, rd_addr2,
    output pend_hit1, pend_hit2,
    output fifo_count
  );

  modport master (
    output a_we, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  b_ready,
    input  rf_we, rf_addr, rf_data,
    input  stall_req,
    output rd_addr1, rd_addr2,
    input  pend_hit1, pend_hit2,
    input  fifo_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between the pipeline
//   writeback (A, fixed priority, never stalled) and a multi-cycle unit (B)
//   whose results wait in a DEPTH-entry FIFO until the port is free.
//   Reports rd_addr hits against pending B entries and raises stall_req once
//   B has been blocked for STARVE_LIMIT consecutive cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : rf_write_arbiter_if.slave (A/B inputs, rf write port, hazard
//           lookups, stall_req, fifo_count)
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic             a_aw;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] ent_valid;
  logic             hit1_c;
  logic             hit2_c;

  assign a_aw       = bus.a_we && (bus.a_addr != 5'd0);
  assign fifo_empty = (count_q == '0);

  // Space is judged from registered occupancy only, so a pop in this cycle
  // never makes room for a push in the same cycle.
  assign bus.b_ready = (count_q < CW'(DEPTH));

  // Writes to r0 complete the handshake but are dropped.
  assign push = bus.b_valid && bus.b_ready && (bus.b_addr != 5'd0);
  assign pop  = !reset && !a_aw && !fifo_empty;

  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_addr = 5'd0;
    bus.rf_data = 32'd0;
    if (!reset) begin
      if (a_aw) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = bus.a_addr;
        bus.rf_data = bus.a_data;
      end else if (!fifo_empty) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = addr_q[rd_ptr_q];
        bus.rf_data = data_q[rd_ptr_q];
      end
    end
  end

  // An entry is live when its distance from the head (mod DEPTH) is below
  // the occupancy; the head being popped this cycle is still live.
  always_comb begin
    logic [AW-1:0] off;
    off       = '0;
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = AW'(i) - rd_ptr_q;
      ent_valid[i] = (CW'(off) < count_q);
    end
  end

  always_comb begin
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (addr_q[i] == bus.rd_addr1)) hit1_c = 1'b1;
      if (ent_valid[i] && (addr_q[i] == bus.rd_addr2)) hit2_c = 1'b1;
    end
  end

  assign bus.pend_hit1 = hit1_c && (bus.rd_addr1 != 5'd0);
  assign bus.pend_hit2 = hit2_c && (bus.rd_addr2 != 5'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Payload storage needs no reset; liveness comes from the pointers/count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      addr_q[wr_ptr_q] <= bus.b_addr;
      data_q[wr_ptr_q] <= bus.b_data;
    end
  end

  assign bus.stall_req  = (starve_q == SW'(STARVE_LIMIT));
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Directed stimulus with literal expectations, plus a queue-based reference
//   model that is compared against every DUT output on each falling edge.
module tb_rf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  rf_write_arbiter_if #(.DEPTH(DEPTH)) bus();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: pending B results as a queue of {addr, data}.
  logic [36:0] mq[$];
  int          m_starve = 0;
  bit          m_aw;
  bit          m_pop;
  bit          m_rdy;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_starve = 0;
    end else begin
      m_aw  = bus.a_we && (bus.a_addr != 5'd0);
      m_rdy = (mq.size() < DEPTH);
      m_pop = !m_aw && (mq.size() > 0);
      if (m_pop || mq.size() == 0) m_starve = 0;
      else if (m_starve < LIMIT)   m_starve++;
      if (m_pop) void'(mq.pop_front());
      if (bus.b_valid && m_rdy && bus.b_addr != 5'd0) mq.push_back({bus.b_addr, bus.b_data});
    end
  end

  always @(negedge clk) begin
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_h1;
    logic        e_h2;
    logic [36:0] ent;
    e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_h1 = 1'b0; e_h2 = 1'b0;
    if (!reset) begin
      if (bus.a_we && bus.a_addr != 5'd0) begin
        e_we = 1'b1; e_addr = bus.a_addr; e_data = bus.a_data;
      end else if (mq.size() > 0) begin
        ent = mq[0];
        e_we = 1'b1; e_addr = ent[36:32]; e_data = ent[31:0];
      end
    end
    foreach (mq[i]) begin
      ent = mq[i];
      if (bus.rd_addr1 != 5'd0 && ent[36:32] == bus.rd_addr1) e_h1 = 1'b1;
      if (bus.rd_addr2 != 5'd0 && ent[36:32] == bus.rd_addr2) e_h2 = 1'b1;
    end
    chk("m_rf_we",     bus.rf_we,      e_we);
    chk("m_rf_addr",   bus.rf_addr,    e_addr);
    chk("m_rf_data",   bus.rf_data,    e_data);
    chk("m_b_ready",   bus.b_ready,    mq.size() < DEPTH);
    chk("m_stall",     bus.stall_req,  m_starve == LIMIT);
    chk("m_count",     bus.fifo_count, mq.size());
    chk("m_pend_hit1", bus.pend_hit1,  e_h1);
    chk("m_pend_hit2", bus.pend_hit2,  e_h2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.a_we = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h0000_AAAA;
    bus.b_valid = 1'b0; bus.b_addr = 5'd0; bus.b_data = 32'd0;
    bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd0;

    // Reset held two cycles with A active
    tick(); #2;
    chk("rst_rf_we",   bus.rf_we,      0);
    chk("rst_b_ready", bus.b_ready,    1);
    chk("rst_count",   bus.fifo_count, 0);
    chk("rst_stall",   bus.stall_req,  0);
    tick();
    reset = 1'b0; #2;
    chk("a_rf_we",   bus.rf_we,   1);
    chk("a_rf_addr", bus.rf_addr, 3);
    chk("a_rf_data", bus.rf_data, 32'h0000_AAAA);
    tick();

    // Single B result, A idle
    bus.a_we = 1'b0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd5; bus.b_data = 32'h1234; #2;
    chk("b_ready_idle", bus.b_ready, 1);
    chk("b_no_bypass",  bus.rf_we,   0);
    tick();
    bus.b_valid = 1'b0; #2;
    chk("b_rf_we",   bus.rf_we,      1);
    chk("b_rf_addr", bus.rf_addr,    5);
    chk("b_rf_data", bus.rf_data,    32'h1234);
    chk("b_count1",  bus.fifo_count, 1);
    tick(); #2;
    chk("b_count0",  bus.fifo_count, 0);

    // Contention: A busy while B fills the FIFO
    bus.a_we = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h77; bus.rd_addr1 = 5'd9;
    for (int k = 0; k < 4; k++) begin
      bus.b_valid = 1'b1; bus.b_addr = 5'(8 + k); bus.b_data = 32'hB0 + k;
      tick();
    end
    bus.b_valid = 1'b0; #2;
    chk("ct_b_ready", bus.b_ready,    0);
    chk("ct_count",   bus.fifo_count, 4);
    chk("ct_hit9",    bus.pend_hit1,  1);
    chk("ct_a_wins",  bus.rf_addr,    7);
    for (int k = 0; k < 5; k++) begin
      chk("ct_stall_early", bus.stall_req, 0);
      tick(); #2;
    end
    chk("ct_stall_on", bus.stall_req, 1);
    tick(); #2;
    chk("ct_stall_sat", bus.stall_req, 1);
    bus.a_we = 1'b0; #1;
    chk("dr_addr8", bus.rf_addr, 8);
    chk("dr_data8", bus.rf_data, 32'hB0);
    tick(); #2;
    chk("dr_addr9",    bus.rf_addr,   9);
    chk("dr_hit9_pop", bus.pend_hit1, 1);
    chk("dr_stall_clr", bus.stall_req, 0);
    tick(); #2;
    chk("dr_addr10",   bus.rf_addr,   10);
    chk("dr_hit9_gone", bus.pend_hit1, 0);
    tick(); #2;
    chk("dr_addr11",   bus.rf_addr,   11);
    chk("dr_data11",   bus.rf_data,   32'hB3);
    tick(); #2;
    chk("dr_empty_we", bus.rf_we,      0);
    chk("dr_count0",   bus.fifo_count, 0);
    bus.rd_addr1 = 5'd0;

    // Register 0 on both ports
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'hDEAD; #1;
    chk("r0_b_ready", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0; #2;
    chk("r0_count", bus.fifo_count, 0);
    chk("r0_no_we", bus.rf_we,      0);
    bus.a_we = 1'b1; bus.a_addr = 5'd12; bus.a_data = 32'hC;
    bus.b_valid = 1'b1; bus.b_addr = 5'd20; bus.b_data = 32'h2020;
    tick();
    bus.b_valid = 1'b0; bus.a_addr = 5'd0; bus.a_data = 32'h999; #2;
    chk("r0a_rf_we",   bus.rf_we,   1);
    chk("r0a_rf_addr", bus.rf_addr, 20);
    chk("r0a_rf_data", bus.rf_data, 32'h2020);
    tick(); #2;
    chk("r0a_count", bus.fifo_count, 0);

    // Fill, then stream B with A idle: one pop per cycle, pointers wrap
    bus.a_we = 1'b1; bus.a_addr = 5'd7;
    for (int k = 0; k < 4; k++) begin
      bus.b_valid = 1'b1; bus.b_addr = 5'(k + 1); bus.b_data = 32'h100 + k;
      tick();
    end
    bus.a_we = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      bus.b_valid = 1'b1; bus.b_addr = 5'(5 + i); bus.b_data = 32'h500 + i; #2;
      chk("fp_rf_addr", bus.rf_addr, (i < 4) ? i + 1 : i + 2);
      if (i == 0) chk("fp_full_ready", bus.b_ready, 0);
      if (i == 1) chk("fp_freed_ready", bus.b_ready, 1);
      chk("fp_count_bound", bus.fifo_count <= DEPTH, 1);
      tick();
    end
    bus.b_valid = 1'b0; bus.rd_addr1 = 5'd16; bus.rd_addr2 = 5'd14; #2;
    chk("fp_count3", bus.fifo_count, 3);
    chk("fp_hit16",  bus.pend_hit1,  1);
    chk("fp_hit14",  bus.pend_hit2,  1);

    // Reset mid-drain
    reset = 1'b1; #1;
    chk("md_rst_we", bus.rf_we, 0);
    tick();
    reset = 1'b0; #2;
    chk("md_count0", bus.fifo_count, 0);
    chk("md_hit1",   bus.pend_hit1,  0);
    chk("md_hit2",   bus.pend_hit2,  0);
    for (int k = 0; k < 3; k++) begin
      chk("md_no_stale", bus.rf_we, 0);
      tick(); #2;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
